// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for data_mem_ctrl
// Access size codes, controller state enum and the wait-counter ceiling.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int unsigned MAX_WAIT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of load data
// Half selects by addr[1] only, so a misaligned half is force-aligned here.
module load_extend
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    result_o = '0;
    case (size_i)
      SZ_BYTE: result_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: result_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      SZ_WORD: result_o = word_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressed data memory with a wait-state request/response FSM
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of force-aligning them.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES);

  logic [31:0] mem_q [DEPTH];

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            req_ready_q, rsp_valid_q, rsp_err_q;
  logic [31:0]     rsp_rdata_q;
  logic            write_q, uns_q, err_q;
  logic [1:0]      size_q, lane_q;
  logic [AW-1:0]   idx_q;

  logic            accept;
  logic            err_d;
  logic [3:0]      strb_d;
  logic [31:0]     wdata_d;
  logic [AW-1:0]   req_idx;

  logic            rd_write, rd_uns, rd_err;
  logic [1:0]      rd_size, rd_lane;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     ext_data;
  logic [31:0]     rdata_d;

  assign accept  = req_valid && req_ready_q;
  assign req_idx = req_addr[AW+1:2];

  always_comb begin
    err_d = ({2'b00, req_addr[31:2]} >= DEPTH) || (req_size == SZ_RSVD);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (req_size == SZ_HALF && req_addr[0])         err_d = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) err_d = 1'b1;
`endif
  end

  always_comb begin
    strb_d  = 4'b0000;
    wdata_d = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        strb_d  = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        strb_d  = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      SZ_WORD: strb_d = 4'b1111;
      default: strb_d = 4'b0000;
    endcase
  end

  // Stores commit on the accepting edge; Reset on the same edge blocks them.
  always_ff @(posedge clk) begin
    if (!Reset && accept && req_write && !err_d) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_d[b]) mem_q[req_idx][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  // With zero wait cycles the response is sampled on the accepting edge, before the fields are latched.
  always_comb begin
    if (state_q == ST_IDLE) begin
      rd_idx   = req_idx;
      rd_lane  = req_addr[1:0];
      rd_size  = req_size;
      rd_uns   = req_unsigned;
      rd_write = req_write;
      rd_err   = err_d;
    end else begin
      rd_idx   = idx_q;
      rd_lane  = lane_q;
      rd_size  = size_q;
      rd_uns   = uns_q;
      rd_write = write_q;
      rd_err   = err_q;
    end
  end

  load_extend u_load_extend (
    .word_i     (mem_q[rd_idx]),
    .addr_i     (rd_lane),
    .size_i     (rd_size),
    .unsigned_i (rd_uns),
    .result_o   (ext_data)
  );

  assign rdata_d = (rd_err || rd_write) ? 32'd0 : ext_data;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx_q       <= req_idx;
            lane_q      <= req_addr[1:0];
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            write_q     <= req_write;
            err_q       <= err_d;
            req_ready_q <= 1'b0;
            if (WAIT_INIT == 4'd0) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err_d;
              rsp_rdata_q <= rdata_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= rdata_d;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized self-checking bench for data_mem_ctrl
// Reference memory is a flat byte array; honours DMEM_MISALIGN_TRAP_EN like the design.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned WAIT  = 2;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_bytes [DEPTH*4];

  data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wd,
                       output logic [31:0] exp_rd, output bit exp_err);
    int nbytes;
    int base;
    logic [31:0] v;
    exp_rd  = 32'd0;
    exp_err = 1'b0;
    nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    if (size == 2'd3 || (addr >> 2) >= DEPTH) exp_err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    else if (addr % nbytes != 0) exp_err = 1'b1;
`endif
    if (exp_err) return;
    base = int'(addr) - int'(addr % nbytes);
    if (wr) begin
      for (int i = 0; i < nbytes; i++) ref_bytes[base+i] = 8'(wd >> (8*i));
    end else begin
      v = 32'd0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_bytes[base+i]) << (8*i));
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
      exp_rd = v;
    end
  endtask

  task automatic start_req(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                           input bit uns, input logic [31:0] wd,
                           output logic [31:0] er, output bit ee);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_size = size; req_unsigned = uns; req_wdata = wd;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    model(wr, addr, size, uns, wd, er, ee);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] er, input bit ee,
                          output logic [31:0] got, output bit gerr);
    int lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (rsp_valid || lat > 40) break;
    end
    check({tag, ":latency"}, 32'(lat), 32'(WAIT + 1));
    check({tag, ":rdata"}, rsp_rdata, er);
    check({tag, ":err"}, 32'(rsp_err), 32'(ee));
    got  = rsp_rdata;
    gerr = rsp_err;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic issue(input string tag, input bit wr, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wd,
                       output logic [31:0] got, output bit gerr);
    logic [31:0] er;
    bit ee;
    start_req(wr, addr, size, uns, wd, er, ee);
    wait_rsp(tag, er, ee, got, gerr);
    finish_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, er, held;
    bit gerr, ee;

    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_err",   32'(rsp_err),   32'd0);
    check("reset_rsp_rdata", rsp_rdata,      32'd0);

    for (int w = 0; w < 16; w++) issue("preload", 1'b1, 32'(4*w), 2'b10, 1'b0, $urandom, got, gerr);
    issue("preload_top", 1'b1, 32'h3FC, 2'b10, 1'b0, 32'hCAFE_F00D, got, gerr);

    issue("sw_10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, got, gerr);
    check("sw_10_rdata_zero", got, 32'd0);
    issue("lw_10", 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, got, gerr);
    check("lw_10_const", got, 32'hDEAD_BEEF);
    issue("lb_13", 1'b0, 32'h13, 2'b00, 1'b0, 32'd0, got, gerr);
    check("lb_13_const", got, 32'hFFFF_FFDE);
    issue("lbu_13", 1'b0, 32'h13, 2'b00, 1'b1, 32'd0, got, gerr);
    check("lbu_13_const", got, 32'h0000_00DE);
    issue("lh_10", 1'b0, 32'h10, 2'b01, 1'b0, 32'd0, got, gerr);
    check("lh_10_const", got, 32'hFFFF_BEEF);
    issue("sb_11", 1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_00AA, got, gerr);
    issue("lw_10_after_sb", 1'b0, 32'h10, 2'b10, 1'b0, 32'd0, got, gerr);
    check("lw_10_after_sb_const", got, 32'hDEAD_AAEF);

    issue("lw_400", 1'b0, 32'h400, 2'b10, 1'b0, 32'd0, got, gerr);
    check("lw_400_err_const", 32'(gerr), 32'd1);
    issue("sw_400", 1'b1, 32'h400, 2'b10, 1'b0, 32'h1111_2222, got, gerr);
    issue("lw_3fc", 1'b0, 32'h3FC, 2'b10, 1'b0, 32'd0, got, gerr);
    check("lw_3fc_const", got, 32'hCAFE_F00D);
    issue("lw_0_no_alias", 1'b0, 32'h0, 2'b10, 1'b0, 32'd0, got, gerr);

    start_req(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, er, ee);
    wait_rsp("stall_lw", er, ee, held, gerr);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
    req_size = 2'b10; req_wdata = 32'hFFFF_FFFF;
    repeat (5) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", rsp_rdata, held);
      check("stall_rsp_err",   32'(rsp_err), 32'(ee));
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    finish_rsp();
    @(negedge clk);
    check("post_stall_req_ready", 32'(req_ready), 32'd1);
    check("post_stall_rsp_valid", 32'(rsp_valid), 32'd0);
    issue("lw_20_ignored_store", 1'b0, 32'h20, 2'b10, 1'b0, 32'd0, got, gerr);

    start_req(1'b1, 32'h34, 2'b10, 1'b0, 32'h1234_5678, er, ee);
    @(negedge clk);
    check("wait_rsp_valid_low", 32'(rsp_valid), 32'd0);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("mid_reset_req_ready", 32'(req_ready), 32'd1);
    check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("mid_reset_no_rsp", 32'(rsp_valid), 32'd0);
    end
    issue("lw_34_after_reset", 1'b0, 32'h34, 2'b10, 1'b0, 32'd0, got, gerr);
    check("lw_34_after_reset_const", got, 32'h1234_5678);

    issue("lw_12", 1'b0, 32'h12, 2'b10, 1'b0, 32'd0, got, gerr);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw_12_trap_err", 32'(gerr), 32'd1);
`else
    check("lw_12_align_rdata", got, 32'hDEAD_AAEF);
`endif

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      bit          wr, un;
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      issue("rand", wr, a, sz, un, $urandom, got, gerr);
    end

    for (int w = 0; w < 16; w++) issue("final_sweep", 1'b0, 32'(4*w), 2'b10, 1'b0, 32'd0, got, gerr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 256, the number of 32-bit words of storage (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, the extra wait cycles before each response (0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-006 SHALL have ports req_write (input, 1; 1 = store), req_addr (input, 32; byte address), req_wdata (input, 32; store data), req_size (input, 2; 00 byte, 01 half, 10 word, 11 reserved) and req_unsigned (input, 1; zero-extend loads).
REQ-007 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_rdata (output, 32; extended load data) and rsp_err (output, 1; request rejected).

Function
REQ-008 SHALL implement the states IDLE, WAIT and RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-009 SHALL accept a request on an edge where req_valid && req_ready, latch all request fields, and move to WAIT with counter = WAIT_CYCLES, or straight to RESP if WAIT_CYCLES = 0.
REQ-010 SHALL decrement the counter once per cycle in WAIT and enter RESP on the edge where it reaches 0; rsp_valid rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-011 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge; no back-to-back bypass (minimum 1 IDLE cycle between responses).
REQ-012 SHALL commit stores on the accepting edge, using byte-lane strobes: byte -> lane addr[1:0] from wdata[7:0]; half -> lanes {addr[1],0} and {addr[1],1} from wdata[15:0]; word -> all four lanes.
REQ-013 SHALL sample read data on entry to RESP; byte/half are selected by address lane and sign-extended, or zero-extended when req_unsigned = 1; word is returned unchanged; stores return rsp_rdata = 0.
REQ-014 SHALL index words by addr[31:2]; an index >= DEPTH sets rsp_err = 1, performs no write, and returns rsp_rdata = 0.
REQ-015 SHALL treat req_size = 11 as an error, with the same behaviour as REQ-014.
REQ-016 SHALL ignore req_valid outside IDLE; a read after a store to the same address returns the stored data.

Reset
REQ-017 SHALL, when Reset = 1 at an edge, enter IDLE and clear the counter, rsp_valid, rsp_err and rsp_rdata to 0, with req_ready = 1 from the next cycle.
REQ-018 SHALL, on Reset mid-operation (WAIT or RESP), discard the pending response; an already-committed store remains; memory contents are never cleared by Reset.
REQ-019 SHALL give Reset priority over a simultaneous request or rsp_ready.

Configuration
REQ-020 SHALL, with macro DMEM_MISALIGN_TRAP_EN defined, flag misaligned accesses (half with addr[0] = 1; word with addr[1:0] != 0) with rsp_err = 1, no write and rsp_rdata = 0.
REQ-021 SHALL, without DMEM_MISALIGN_TRAP_EN, force-align misaligned accesses (clear addr[0] for half, addr[1:0] for word) and complete them without error.

Structure
REQ-022 SHALL place the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum and MAX_WAIT = 15 in shared package dmem_pkg.
REQ-023 SHALL put lane select and extension in combinational sub-module load_extend (inputs: word, addr[1:0], size, unsigned; output: 32-bit result).

Verification
REQ-024 SHALL cover: WAIT_CYCLES = 2; sw 0xDEADBEEF to 0x10, then lw 0x10 -> rsp_valid 3 cycles after each accept, rdata 0xDEADBEEF, err 0.
REQ-025 SHALL cover: after REQ-024, lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x10 -> 0xFFFFBEEF; sb 0xAA to 0x11 then lw 0x10 -> 0xDEADAAEF.
REQ-026 SHALL cover: DEPTH = 256, lw 0x400 -> err 1, rdata 0; a following lw 0x3FC returns prior contents unaltered.
REQ-027 SHALL cover: rsp_ready held low 5 cycles in RESP -> outputs stable, req_ready 0, a new req_valid ignored; rsp_ready high -> IDLE next cycle.
REQ-028 SHALL cover: Reset asserted in WAIT -> next cycle IDLE, rsp_valid 0, req_ready 1; the committed store remains readable.
REQ-029 SHALL cover: lw 0x12 with the macro -> err 1; without the macro -> word at 0x10, err 0.
